// File: rtl/multibyte_serial_adder_pkg.sv
// Shared constants and state encoding for the byte-serial wide adder.
package multibyte_serial_adder_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/multibyte_serial_adder_full_adder_8bit.sv
// 8-bit ripple adder slice; the wrapper reuses it once per byte.
module full_adder_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c_in,
   output logic [7:0] sum,
   output logic       c_out
);

   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, c_in};

endmodule

// File: rtl/multibyte_serial_adder.sv
// Adds two NUM_BYTES-wide operands one byte per clock through a single 8-bit
// adder, carrying between bytes in a register.
module multibyte_serial_adder
   import multibyte_serial_adder_pkg::*;
#(
   parameter int NUM_BYTES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [BYTE_W*NUM_BYTES-1:0] a,
   input  logic [BYTE_W*NUM_BYTES-1:0] b,
   input  logic                        c_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BYTE_W*NUM_BYTES-1:0] sum,
   output logic                        c_out,
   output logic                        busy
);

   localparam int W     = BYTE_W * NUM_BYTES;
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               c_out_q, c_out_d;

   logic [BYTE_W-1:0]  fa_sum;
   logic               fa_c_out;

   full_adder_8bit u_fa8 (
      .a     (a_q[idx_q*BYTE_W +: BYTE_W]),
      .b     (b_q[idx_q*BYTE_W +: BYTE_W]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_c_out)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d[idx_q*BYTE_W +: BYTE_W] = fa_sum;
            carry_d = fa_c_out;
            if (idx_q == LAST_IDX) begin
               c_out_d = fa_c_out;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == ADD);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign c_out     = c_out_q;

endmodule

// File: tb/tb_multibyte_serial_adder.sv
// Directed and randomised checks of the byte-serial adder at NUM_BYTES=4 and NUM_BYTES=1.
module tb_multibyte_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
   logic [31:0] a, b, sum;

   logic        in_valid_1, in_ready_1, c_in_1, out_valid_1, out_ready_1, c_out_1, busy_1;
   logic [7:0]  a_1, b_1, sum_1;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multibyte_serial_adder #(.NUM_BYTES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .busy(busy)
   );

   multibyte_serial_adder #(.NUM_BYTES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
      .a(a_1), .b(b_1), .c_in(c_in_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
      .sum(sum_1), .c_out(c_out_1), .busy(busy_1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Handoff from DONE with out_ready high, then confirm return to IDLE.
   task automatic finish4();
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("out_valid_after_handoff", 64'(out_valid), 64'd1 - 64'd1);
      check("in_ready_after_handoff", 64'(in_ready), 64'd1);
   endtask

   // One 4-byte operation; leaves the DUT in DONE when handoff is 0.
   task automatic op4(input logic [31:0] a_v, input logic [31:0] b_v, input logic c_v,
                      input bit handoff);
      logic [32:0] ref_v;
      int          lat;
      ref_v = {1'b0, a_v} + {1'b0, b_v} + 33'(c_v);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      a = a_v; b = b_v; c_in = c_v; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; c_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         check("busy_add", 64'(busy), 64'd1);
         check("in_ready_add", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      check("sum", 64'(sum), 64'(ref_v[31:0]));
      check("c_out", 64'(c_out), 64'(ref_v[32]));
      check("in_ready_done", 64'(in_ready), 64'd0);
      check("busy_done", 64'(busy), 64'd0);
      if (handoff) finish4();
   endtask

   // One 1-byte operation on the NUM_BYTES=1 instance.
   task automatic op1(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v);
      logic [8:0] ref_v;
      ref_v = {1'b0, a_v} + {1'b0, b_v} + 9'(c_v);
      a_1 = a_v; b_1 = b_v; c_in_1 = c_v; in_valid_1 = 1'b1;
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      @(posedge clk); #1;
      check("nb1_out_valid", 64'(out_valid_1), 64'd1);
      check("nb1_result", 64'({c_out_1, sum_1}), 64'(ref_v));
      @(posedge clk); #1;
      check("nb1_in_ready", 64'(in_ready_1), 64'd1);
   endtask

   initial begin
      logic [32:0] res [2];
      int          n_res;
      int          acc_cyc [$];
      bit          accept_now;
      int          spacing;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
      in_valid_1 = 1'b0; out_ready_1 = 1'b1; a_1 = '0; b_1 = '0; c_in_1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_c_out", 64'(c_out), 64'd0);

      // Test 1 and 2: byte carry and full ripple.
      op4(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
      op4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);

      // Test 3: backpressure hold with ignored input pulses.
      out_ready = 1'b0;
      op4(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         a = $urandom; b = $urandom; in_valid = 1'b1;
         @(posedge clk); #1;
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_sum", 64'(sum), 64'h0000_0001);
         check("hold_c_out", 64'(c_out), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      finish4();

      // Test 4: reset during the second ADD cycle discards the operation.
      a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_sum", 64'(sum), 64'd0);
      check("midrst_c_out", 64'(c_out), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("midrst_no_result", 64'(out_valid), 64'd0);
      end
      op4(32'd1, 32'd2, 1'b0, 1'b1);

      // Test 5: back-to-back with in_valid and out_ready tied high.
      a = 32'h7F7F_7F7F; b = 32'h7F7F_7F7F; c_in = 1'b0; in_valid = 1'b1;
      n_res = 0;
      for (int k = 0; k < 40 && n_res < 2; k++) begin
         accept_now = in_valid && in_ready;
         @(posedge clk); #1;
         if (accept_now) begin
            acc_cyc.push_back(cyc);
            c_in = ~c_in;
         end
         if (out_valid) begin
            res[n_res] = {c_out, sum};
            n_res++;
            if (n_res == 2) in_valid = 1'b0;
         end
      end
      check("b2b_results", 64'(n_res), 64'd2);
      check("b2b_res0", 64'(res[0]), 64'({1'b0, 32'h7F7F_7F7F} + {1'b0, 32'h7F7F_7F7F}));
      check("b2b_res1", 64'(res[1]), 64'({1'b0, 32'h7F7F_7F7F} + {1'b0, 32'h7F7F_7F7F} + 33'd1));
      spacing = (acc_cyc.size() >= 2) ? (acc_cyc[1] - acc_cyc[0]) : -1;
      check("b2b_accepts", 64'(acc_cyc.size()), 64'd2);
      check("b2b_spacing", 64'(spacing), 64'd6);
      @(posedge clk); #1;
      check("b2b_idle", 64'(in_ready), 64'd1);

      // Test 6a: randomised sweep with some forced full-ripple cases.
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (n % 8 == 0) ? ~ra : $urandom;
         op4(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      end

      // Test 6b: NUM_BYTES=1 build, every a against sampled b and both carries.
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 16; j++) begin
            logic [7:0] bv;
            bv = (j == 0) ? 8'hFF : ((j == 1) ? 8'h00 : 8'($urandom));
            op1(8'(i), bv, 1'(j % 2));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
